exp_normalize_seq: RTL and testbench

- Sequential post-add normalizer for the FP adder exponent path. It runs after exponent compare/swap, alignment and the mantissa add/sub.
- It takes the larger operand's exponent and the raw sum mantissa. A carry is resolved with a 1-bit right shift; leading zeros are removed with a 1-bit-per-cycle left shift.
- It returns the normalized exponent/mantissa pair to the rounding stage over valid/ready handshakes.

---
 rtl/exp_normalize_seq.sv | 189 ++++++++++++++++++
 tb/tb_exp_normalize_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/exp_normalize_seq.sv
`default_nettype none
// ============================================================================
// Module   : exp_normalize_seq
// Purpose  : Post-add FP normalizer: carry right-shift, 1-bit/cycle left-shift.
// Revision : 1.0 - initial release
// ============================================================================
module exp_normalize_seq #(
    parameter int SIZE_EXP = 8,
    parameter int SIZE_MAN = 27,
    parameter int SIZE_CNT = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [SIZE_EXP-1:0] i_exp,
    input  logic [SIZE_MAN-1:0] i_man,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SIZE_EXP-1:0] o_exp,
    output logic [SIZE_MAN-1:0] o_man,
    output logic [SIZE_CNT-1:0] o_shift_count,
    output logic                o_zero,
    output logic                o_overflow,
    output logic                o_denormal
);

    localparam int                c_HID      = SIZE_MAN - 2;
    localparam int                c_CAR      = SIZE_MAN - 1;
    localparam logic [SIZE_EXP-1:0] c_EXP_ONE  = SIZE_EXP'(1);
    localparam logic [SIZE_EXP-1:0] c_EXP_ONES = {SIZE_EXP{1'b1}};
    localparam logic [SIZE_CNT-1:0] c_CNT_ONE  = SIZE_CNT'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_valid;
    logic [SIZE_EXP-1:0] r_exp;
    logic [SIZE_MAN-1:0] r_man;
    logic [SIZE_CNT-1:0] r_cnt;
    logic [SIZE_EXP-1:0] r_o_exp;
    logic [SIZE_MAN-1:0] r_o_man;
    logic [SIZE_CNT-1:0] r_o_cnt;
    logic                r_o_zero;
    logic                r_o_ovf;
    logic                r_o_den;

    logic                w_cls_done;
    logic [SIZE_EXP-1:0] w_cls_exp;
    logic [SIZE_MAN-1:0] w_cls_man;
    logic                w_cls_zero;
    logic                w_cls_ovf;
    logic                w_cls_den;
    logic [SIZE_EXP-1:0] w_exp_inc;

    logic                w_do_shift;
    logic [SIZE_EXP-1:0] w_exp_nx;
    logic [SIZE_MAN-1:0] w_man_nx;
    logic [SIZE_CNT-1:0] w_cnt_nx;
    logic                w_fin;

    // Classification of an incoming operand; anything not resolved here needs left shifts.
    always_comb begin
        w_exp_inc  = i_exp + c_EXP_ONE;
        w_cls_done = 1'b1;
        w_cls_exp  = i_exp;
        w_cls_man  = i_man;
        w_cls_zero = 1'b0;
        w_cls_ovf  = 1'b0;
        w_cls_den  = 1'b0;
        if (i_exp == c_EXP_ONES) begin
            w_cls_done = 1'b1;
        end else if (i_man == '0) begin
            w_cls_exp  = '0;
            w_cls_man  = '0;
            w_cls_zero = 1'b1;
        end else if (i_man[c_CAR]) begin
            if (w_exp_inc == c_EXP_ONES) begin
                w_cls_exp = c_EXP_ONES;
                w_cls_man = '0;
                w_cls_ovf = 1'b1;
            end else begin
                w_cls_exp = w_exp_inc;
                w_cls_man = {1'b0, i_man[c_CAR:2], i_man[1] | i_man[0]};
            end
        end else if (i_exp == '0) begin
            if (i_man[c_HID]) begin
                w_cls_exp = c_EXP_ONE;
            end else begin
                w_cls_exp = '0;
                w_cls_den = 1'b1;
            end
        end else if (!i_man[c_HID]) begin
            w_cls_done = 1'b0;
        end
    end

    always_comb begin
        w_do_shift = !r_man[c_HID] && (r_exp > c_EXP_ONE);
        w_man_nx   = w_do_shift ? (r_man << 1) : r_man;
        w_exp_nx   = w_do_shift ? (r_exp - c_EXP_ONE) : r_exp;
        w_cnt_nx   = w_do_shift ? (r_cnt + c_CNT_ONE) : r_cnt;
        w_fin      = w_man_nx[c_HID] || (w_exp_nx <= c_EXP_ONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_exp    <= '0;
            r_man    <= '0;
            r_cnt    <= '0;
            r_o_exp  <= '0;
            r_o_man  <= '0;
            r_o_cnt  <= '0;
            r_o_zero <= 1'b0;
            r_o_ovf  <= 1'b0;
            r_o_den  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                        r_exp   <= i_exp;
                        r_man   <= i_man;
                        if (w_cls_done) begin
                            r_state  <= S_DONE;
                            r_valid  <= 1'b1;
                            r_o_exp  <= w_cls_exp;
                            r_o_man  <= w_cls_man;
                            r_o_cnt  <= '0;
                            r_o_zero <= w_cls_zero;
                            r_o_ovf  <= w_cls_ovf;
                            r_o_den  <= w_cls_den;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_exp <= w_exp_nx;
                    r_man <= w_man_nx;
                    r_cnt <= w_cnt_nx;
                    if (w_fin) begin
                        // Bottoming out at exponent 1 without a hidden bit yields a denormal.
                        r_state  <= S_DONE;
                        r_valid  <= 1'b1;
                        r_o_exp  <= w_man_nx[c_HID] ? w_exp_nx : '0;
                        r_o_man  <= w_man_nx;
                        r_o_cnt  <= w_cnt_nx;
                        r_o_zero <= 1'b0;
                        r_o_ovf  <= 1'b0;
                        r_o_den  <= !w_man_nx[c_HID];
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready       = r_ready;
    assign o_valid       = r_valid;
    assign o_exp         = r_o_exp;
    assign o_man         = r_o_man;
    assign o_shift_count = r_o_cnt;
    assign o_zero        = r_o_zero;
    assign o_overflow    = r_o_ovf;
    assign o_denormal    = r_o_den;

endmodule
`default_nettype wire

// File: tb/tb_exp_normalize_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp_normalize_seq
// Purpose  : Directed self-checking bench for exp_normalize_seq.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_exp_normalize_seq;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_exp;
    logic [26:0] i_man;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_exp;
    logic [26:0] o_man;
    logic [4:0]  o_shift_count;
    logic        o_zero;
    logic        o_overflow;
    logic        o_denormal;

    int checks   = 0;
    int failures = 0;

    exp_normalize_seq #(.SIZE_EXP(8), .SIZE_MAN(27), .SIZE_CNT(5)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_exp         (i_exp),
        .i_man         (i_man),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_exp         (o_exp),
        .o_man         (o_man),
        .o_shift_count (o_shift_count),
        .o_zero        (o_zero),
        .o_overflow    (o_overflow),
        .o_denormal    (o_denormal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one operand, wait (bounded) for o_valid and check the result.
    task automatic run(input string tag, input logic [7:0] e, input logic [26:0] m,
                       input logic rdy, input int e_lat, input logic [7:0] e_exp,
                       input logic [26:0] e_man, input logic [4:0] e_cnt,
                       input logic e_zero, input logic e_ovf, input logic e_den);
        int lat;
        i_exp   = e;
        i_man   = m;
        i_valid = 1'b1;
        i_ready = rdy;
        tick();
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, lat, e_lat);
        chk({tag, ".valid"}, o_valid, 1);
        chk({tag, ".ready"}, o_ready, 0);
        chk({tag, ".exp"}, o_exp, e_exp);
        chk({tag, ".man"}, o_man, e_man);
        chk({tag, ".cnt"}, o_shift_count, e_cnt);
        chk({tag, ".flags"}, {o_zero, o_overflow, o_denormal}, {e_zero, e_ovf, e_den});
    endtask

    task automatic drain(input string tag);
        i_ready = 1'b1;
        tick();
        chk({tag, ".drain_valid"}, o_valid, 0);
        chk({tag, ".drain_ready"}, o_ready, 1);
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_exp   = '0;
        i_man   = '0;
        tick();
        tick();
        chk("reset.valid", o_valid, 0);
        chk("reset.ready", o_ready, 1);
        chk("reset.data", {o_exp, o_man, o_shift_count}, 0);
        chk("reset.flags", {o_zero, o_overflow, o_denormal}, 0);
        rst = 1'b0;
        tick();

        // Reset while shifting: 0x100 needs 17 shifts, so it is mid-SHIFT.
        i_exp   = 8'd100;
        i_man   = 27'h0000100;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        chk("rst_shift.busy", o_ready, 0);
        rst = 1'b1;
        #1;
        chk("rst_shift.valid", o_valid, 0);
        chk("rst_shift.ready", o_ready, 1);
        chk("rst_shift.data", {o_exp, o_man, o_shift_count}, 0);
        tick();
        rst = 1'b0;
        tick();

        run("lshift", 8'd100, 27'h0800000, 1'b1, 3, 8'd98, 27'h2000000, 5'd2, 0, 0, 0);
        drain("lshift");

        run("carry", 8'd10, 27'h4000001, 1'b1, 1, 8'd11, 27'h2000001, 5'd0, 0, 0, 0);
        drain("carry");

        run("ovf", 8'd254, 27'h4000000, 1'b1, 1, 8'd255, 27'h0, 5'd0, 0, 1, 0);
        drain("ovf");

        run("denorm", 8'd3, 27'h0100000, 1'b1, 3, 8'd0, 27'h0400000, 5'd2, 0, 0, 1);
        drain("denorm");

        run("zero", 8'd77, 27'h0, 1'b1, 1, 8'd0, 27'h0, 5'd0, 1, 0, 0);
        drain("zero");

        run("infnan", 8'd255, 27'h1234567, 1'b1, 1, 8'd255, 27'h1234567, 5'd0, 0, 0, 0);
        drain("infnan");

        // Backpressure: hold the result while a competing operand is offered.
        run("bp", 8'd10, 27'h2000000, 1'b0, 1, 8'd10, 27'h2000000, 5'd0, 0, 0, 0);
        i_valid = 1'b1;
        i_exp   = 8'd50;
        i_man   = 27'h0000001;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp.hold_valid", o_valid, 1);
            chk("bp.hold_ready", o_ready, 0);
            chk("bp.hold_data", {o_exp, o_man, o_shift_count}, {8'd10, 27'h2000000, 5'd0});
        end
        i_valid = 1'b0;
        drain("bp");

        run("exp0_den", 8'd0, 27'h0000010, 1'b1, 1, 8'd0, 27'h0000010, 5'd0, 0, 0, 1);
        drain("exp0_den");

        run("exp0_norm", 8'd0, 27'h2000004, 1'b1, 1, 8'd1, 27'h2000004, 5'd0, 0, 0, 0);
        drain("exp0_norm");

        run("maxshift", 8'd200, 27'h0000001, 1'b1, 26, 8'd175, 27'h2000000, 5'd25, 0, 0, 0);
        drain("maxshift");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
